// File: rtl/rv_writeback_pkg.sv
// Shared uRV definitions: load/store funct3 codes, writeback FSM states and
// the sign/zero extension helpers used by the load aligner.
package rv_defs;

   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_L  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   typedef enum logic [1:0] {
      WB_IDLE       = 2'd0,
      WB_LOAD_WAIT  = 2'd1,
      WB_STORE_WAIT = 2'd2
   } wb_state_t;

   function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
      return {{24{sgn & b[7]}}, b};
   endfunction

   function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
      return {{16{sgn & h[15]}}, h};
   endfunction

endpackage

// File: rtl/rv_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword out of the
// data-memory word and sign- or zero-extends it according to funct3.
module rv_load_align
   import rv_defs::*;
(
   input  logic [2:0]  fun_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] raw_i,
   output logic [31:0] value_o
);

   logic [7:0]  byte_lane [4];
   logic [15:0] half_lane [2];
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte
         assign byte_lane[gi] = raw_i[8*gi +: 8];
      end
      for (gi = 0; gi < 2; gi++) begin : g_half
         assign half_lane[gi] = raw_i[16*gi +: 16];
      end
   endgenerate

   always_comb begin
      sel_byte = byte_lane[addr_i];
      sel_half = half_lane[addr_i[1]];
      value_o  = 32'h0;
      case (fun_i)
         LDST_B:  value_o = ext_byte(sel_byte, 1'b1);
         LDST_BU: value_o = ext_byte(sel_byte, 1'b0);
         LDST_H:  value_o = ext_half(sel_half, 1'b1);
         LDST_HU: value_o = ext_half(sel_half, 1'b0);
         // Word loads ignore the low address bits: no misalignment trap.
         LDST_L:  value_o = raw_i;
         default: value_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/rv_writeback.sv
// uRV writeback stage: retires ALU results, completes loads, stalls on
// outstanding memory responses (with a watchdog) and keeps a bypass entry.
module rv_writeback
   import rv_defs::*;
#(
   parameter int g_timeout = 16
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [2:0]  x_fun_i,
   input  logic        x_load_i,
   input  logic        x_store_i,
   input  logic [4:0]  x_rd_i,
   input  logic [31:0] x_rd_value_i,
   input  logic        x_rd_write_i,
   input  logic [31:0] x_dm_addr_i,
   input  logic [31:0] dm_data_l_i,
   input  logic        dm_load_done_i,
   input  logic        dm_store_done_i,
   output logic        w_stall_req_o,
   output logic        rf_rd_write_o,
   output logic [4:0]  rf_rd_o,
   output logic [31:0] rf_rd_value_o,
   output logic [4:0]  bypass_rd_o,
   output logic [31:0] bypass_value_o,
   output logic        bypass_valid_o,
   output logic        timeout_o
);

   localparam int CW = (g_timeout > 1) ? $clog2(g_timeout) : 1;

   wb_state_t   state_reg, state_next;
   logic [4:0]  rd_reg;
   logic [2:0]  fun_reg;
   logic [1:0]  addr_reg;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [4:0]  bypass_rd_reg;
   logic [31:0] bypass_value_reg;
   logic        bypass_valid_reg;

   logic        latch_req;
   logic        wr_next;
   logic [4:0]  rd_next;
   logic [31:0] value_next;
   logic        stall_next;
   logic        timeout_next;
   logic        wd_expire;
   logic        rf_write;

   logic [2:0]  align_fun;
   logic [1:0]  align_addr;
   logic [31:0] align_value;

   logic        unused_addr_bits;
   assign unused_addr_bits = ^x_dm_addr_i[31:2];

   // A same-cycle load response must use the live inputs, a delayed one the
   // values latched when the load left execute.
   assign align_fun  = (state_reg == WB_IDLE) ? x_fun_i          : fun_reg;
   assign align_addr = (state_reg == WB_IDLE) ? x_dm_addr_i[1:0] : addr_reg;

   rv_load_align u_align (
      .fun_i   (align_fun),
      .addr_i  (align_addr),
      .raw_i   (dm_data_l_i),
      .value_o (align_value)
   );

   assign wd_expire = (g_timeout > 0) && (cnt_reg == CW'(g_timeout - 1));

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      latch_req    = 1'b0;
      wr_next      = 1'b0;
      rd_next      = 5'd0;
      value_next   = 32'h0;
      stall_next   = 1'b0;
      timeout_next = 1'b0;

      case (state_reg)
         WB_IDLE: begin
            if (x_load_i) begin
               latch_req = 1'b1;
               if (dm_load_done_i) begin
                  wr_next    = 1'b1;
                  rd_next    = x_rd_i;
                  value_next = align_value;
               end else begin
                  stall_next = 1'b1;
                  state_next = WB_LOAD_WAIT;
                  cnt_next   = '0;
               end
            end else if (x_store_i) begin
               if (!dm_store_done_i) begin
                  stall_next = 1'b1;
                  state_next = WB_STORE_WAIT;
                  cnt_next   = '0;
               end
            end else if (x_rd_write_i) begin
               wr_next    = 1'b1;
               rd_next    = x_rd_i;
               value_next = x_rd_value_i;
            end
         end

         WB_LOAD_WAIT: begin
            rd_next = rd_reg;
            if (dm_load_done_i) begin
               wr_next    = 1'b1;
               value_next = align_value;
               state_next = WB_IDLE;
            end else if (wd_expire) begin
               wr_next      = 1'b1;
               value_next   = 32'h0;
               timeout_next = 1'b1;
               state_next   = WB_IDLE;
            end else begin
               stall_next = 1'b1;
               if (g_timeout > 0)
                  cnt_next = cnt_reg + CW'(1);
            end
         end

         WB_STORE_WAIT: begin
            if (dm_store_done_i) begin
               state_next = WB_IDLE;
            end else if (wd_expire) begin
               timeout_next = 1'b1;
               state_next   = WB_IDLE;
            end else begin
               stall_next = 1'b1;
               if (g_timeout > 0)
                  cnt_next = cnt_reg + CW'(1);
            end
         end

         default: state_next = WB_IDLE;
      endcase
   end

   // x0 is never written; the combinational outputs are also held low while
   // reset is asserted so an asynchronous reset silences them immediately.
   assign rf_write       = wr_next && (rd_next != 5'd0);
   assign rf_rd_write_o  = rf_write && !rst_i;
   assign rf_rd_o        = rst_i ? 5'd0  : rd_next;
   assign rf_rd_value_o  = rst_i ? 32'h0 : value_next;
   assign w_stall_req_o  = stall_next && !rst_i;
   assign timeout_o      = timeout_next && !rst_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg        <= WB_IDLE;
         cnt_reg          <= '0;
         rd_reg           <= 5'd0;
         fun_reg          <= 3'd0;
         addr_reg         <= 2'd0;
         bypass_rd_reg    <= 5'd0;
         bypass_value_reg <= 32'h0;
         bypass_valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (latch_req) begin
            rd_reg   <= x_rd_i;
            fun_reg  <= x_fun_i;
            addr_reg <= x_dm_addr_i[1:0];
         end
         if (rf_write) begin
            bypass_rd_reg    <= rd_next;
            bypass_value_reg <= value_next;
            bypass_valid_reg <= 1'b1;
         end
      end
   end

   assign bypass_rd_o    = bypass_rd_reg;
   assign bypass_value_o = bypass_value_reg;
   assign bypass_valid_o = bypass_valid_reg;

endmodule

// File: tb/tb_rv_writeback.sv
// Directed bench for rv_writeback: ALU retire, load alignment, delayed loads,
// stores, watchdog and asynchronous reset during a pending load.
module tb_rv_writeback;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [2:0]  x_fun_i = 3'd0;
   logic        x_load_i = 1'b0;
   logic        x_store_i = 1'b0;
   logic [4:0]  x_rd_i = 5'd0;
   logic [31:0] x_rd_value_i = 32'h0;
   logic        x_rd_write_i = 1'b0;
   logic [31:0] x_dm_addr_i = 32'h0;
   logic [31:0] dm_data_l_i = 32'h0;
   logic        dm_load_done_i = 1'b0;
   logic        dm_store_done_i = 1'b0;
   logic        w_stall_req_o;
   logic        rf_rd_write_o;
   logic [4:0]  rf_rd_o;
   logic [31:0] rf_rd_value_o;
   logic [4:0]  bypass_rd_o;
   logic [31:0] bypass_value_o;
   logic        bypass_valid_o;
   logic        timeout_o;

   int n_checks = 0;
   int n_fail   = 0;

   rv_writeback #(.g_timeout(4)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .x_fun_i         (x_fun_i),
      .x_load_i        (x_load_i),
      .x_store_i       (x_store_i),
      .x_rd_i          (x_rd_i),
      .x_rd_value_i    (x_rd_value_i),
      .x_rd_write_i    (x_rd_write_i),
      .x_dm_addr_i     (x_dm_addr_i),
      .dm_data_l_i     (dm_data_l_i),
      .dm_load_done_i  (dm_load_done_i),
      .dm_store_done_i (dm_store_done_i),
      .w_stall_req_o   (w_stall_req_o),
      .rf_rd_write_o   (rf_rd_write_o),
      .rf_rd_o         (rf_rd_o),
      .rf_rd_value_o   (rf_rd_value_o),
      .bypass_rd_o     (bypass_rd_o),
      .bypass_value_o  (bypass_value_o),
      .bypass_valid_o  (bypass_valid_o),
      .timeout_o       (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   // Inputs change on the falling edge; outputs are sampled 2 ns later.
   task automatic next_cycle();
      @(negedge clk_i);
      x_fun_i = 3'd0; x_load_i = 1'b0; x_store_i = 1'b0; x_rd_i = 5'd0;
      x_rd_value_i = 32'h0; x_rd_write_i = 1'b0; x_dm_addr_i = 32'h0;
      dm_data_l_i = 32'h0; dm_load_done_i = 1'b0; dm_store_done_i = 1'b0;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
      settle();
      n_checks++; if (w_stall_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", w_stall_req_o); end
      n_checks++; if (rf_rd_write_o !== 1'b0) begin n_fail++; $display("FAIL reset_rf_write got=%b exp=0", rf_rd_write_o); end
      n_checks++; if (bypass_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_bypass_valid got=%b exp=0", bypass_valid_o); end
      n_checks++; if ({bypass_rd_o, bypass_value_o} !== 37'h0) begin n_fail++; $display("FAIL reset_bypass got rd=%0d val=%h exp 0", bypass_rd_o, bypass_value_o); end
      n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", timeout_o); end
      next_cycle();
      rst_i = 1'b0;
      $display("txn reset released");
   endtask

   task automatic test_alu();
      next_cycle();
      x_rd_write_i = 1'b1; x_rd_i = 5'd5; x_rd_value_i = 32'h1234;
      settle();
      $display("txn alu rd=5 value=00001234");
      n_checks++; if ({rf_rd_write_o, rf_rd_o, rf_rd_value_o} !== {1'b1, 5'd5, 32'h1234}) begin n_fail++; $display("FAIL alu_rf got w=%b rd=%0d val=%h exp w=1 rd=5 val=00001234", rf_rd_write_o, rf_rd_o, rf_rd_value_o); end
      n_checks++; if (w_stall_req_o !== 1'b0) begin n_fail++; $display("FAIL alu_stall got=%b exp=0", w_stall_req_o); end
      n_checks++; if (bypass_valid_o !== 1'b0) begin n_fail++; $display("FAIL alu_bypass_early got=%b exp=0", bypass_valid_o); end
      // x0 write is suppressed and must leave the bypass untouched.
      next_cycle();
      x_rd_write_i = 1'b1; x_rd_i = 5'd0; x_rd_value_i = 32'hDEAD;
      settle();
      $display("txn alu rd=0 value=0000dead");
      n_checks++; if ({bypass_valid_o, bypass_rd_o, bypass_value_o} !== {1'b1, 5'd5, 32'h1234}) begin n_fail++; $display("FAIL alu_bypass got v=%b rd=%0d val=%h exp v=1 rd=5 val=00001234", bypass_valid_o, bypass_rd_o, bypass_value_o); end
      n_checks++; if (rf_rd_write_o !== 1'b0) begin n_fail++; $display("FAIL alu_x0_write got=%b exp=0", rf_rd_write_o); end
      next_cycle();
      settle();
      n_checks++; if ({bypass_rd_o, bypass_value_o} !== {5'd5, 32'h1234}) begin n_fail++; $display("FAIL alu_x0_bypass got rd=%0d val=%h exp rd=5 val=00001234", bypass_rd_o, bypass_value_o); end
   endtask

   task automatic test_zero_wait_load();
      logic [2:0]  v_fun  [7] = '{3'b000, 3'b001, 3'b100, 3'b010, 3'b001, 3'b011, 3'b000};
      logic [1:0]  v_addr [7] = '{2'd3, 2'd0, 2'd1, 2'd3, 2'd3, 2'd0, 2'd1};
      logic [31:0] v_data [7] = '{32'h80FFFF7F, 32'h12348001, 32'h0000AB00, 32'hCAFEBABE,
                                  32'h80011234, 32'hFFFFFFFF, 32'h00007F00};
      logic [31:0] v_exp  [7] = '{32'hFFFFFF80, 32'hFFFF8001, 32'h000000AB, 32'hCAFEBABE,
                                  32'hFFFF8001, 32'h00000000, 32'h0000007F};
      for (int i = 0; i < 7; i++) begin
         next_cycle();
         x_load_i = 1'b1; x_fun_i = v_fun[i]; x_rd_i = 5'(16 + i);
         x_dm_addr_i = {30'h40, v_addr[i]}; dm_data_l_i = v_data[i]; dm_load_done_i = 1'b1;
         settle();
         $display("txn load0 fun=%0d a=%0d data=%h rd=%0d value=%h", v_fun[i], v_addr[i], v_data[i], rf_rd_o, rf_rd_value_o);
         n_checks++; if ({rf_rd_write_o, rf_rd_o, rf_rd_value_o} !== {1'b1, 5'(16 + i), v_exp[i]}) begin n_fail++; $display("FAIL load0_%0d got w=%b rd=%0d val=%h exp w=1 rd=%0d val=%h", i, rf_rd_write_o, rf_rd_o, rf_rd_value_o, 16 + i, v_exp[i]); end
         n_checks++; if (w_stall_req_o !== 1'b0) begin n_fail++; $display("FAIL load0_stall_%0d got=%b exp=0", i, w_stall_req_o); end
      end
      next_cycle();
      settle();
      n_checks++; if ({w_stall_req_o, bypass_rd_o, bypass_value_o} !== {1'b0, 5'd22, 32'h7F}) begin n_fail++; $display("FAIL load0_bypass got stall=%b rd=%0d val=%h exp stall=0 rd=22 val=0000007f", w_stall_req_o, bypass_rd_o, bypass_value_o); end
   endtask

   task automatic test_delayed_load();
      int stalls = 0;
      next_cycle();
      x_load_i = 1'b1; x_fun_i = 3'b101; x_rd_i = 5'd9; x_dm_addr_i = 32'h2;
      settle();
      stalls += int'(w_stall_req_o);
      n_checks++; if (rf_rd_write_o !== 1'b0) begin n_fail++; $display("FAIL dload_issue_write got=%b exp=0", rf_rd_write_o); end
      for (int c = 1; c < 3; c++) begin
         next_cycle();
         // Junk on the execute side must be ignored while waiting.
         x_rd_write_i = 1'b1; x_rd_i = 5'd3; x_rd_value_i = 32'h77; x_fun_i = 3'b000;
         settle();
         stalls += int'(w_stall_req_o);
         n_checks++; if (rf_rd_write_o !== 1'b0) begin n_fail++; $display("FAIL dload_wait_write_%0d got=%b exp=0", c, rf_rd_write_o); end
      end
      next_cycle();
      dm_load_done_i = 1'b1; dm_data_l_i = 32'hBEEF0000;
      settle();
      $display("txn dload rd=%0d value=%h stall_cycles=%0d", rf_rd_o, rf_rd_value_o, stalls);
      n_checks++; if ({rf_rd_write_o, rf_rd_o, rf_rd_value_o} !== {1'b1, 5'd9, 32'h0000BEEF}) begin n_fail++; $display("FAIL dload_rf got w=%b rd=%0d val=%h exp w=1 rd=9 val=0000beef", rf_rd_write_o, rf_rd_o, rf_rd_value_o); end
      n_checks++; if (w_stall_req_o !== 1'b0) begin n_fail++; $display("FAIL dload_done_stall got=%b exp=0", w_stall_req_o); end
      n_checks++; if (stalls !== 3) begin n_fail++; $display("FAIL dload_stall_count got=%0d exp=3", stalls); end
      next_cycle();
      settle();
      n_checks++; if ({w_stall_req_o, bypass_rd_o, bypass_value_o} !== {1'b0, 5'd9, 32'h0000BEEF}) begin n_fail++; $display("FAIL dload_bypass got stall=%b rd=%0d val=%h exp stall=0 rd=9 val=0000beef", w_stall_req_o, bypass_rd_o, bypass_value_o); end
   endtask

   task automatic test_store_wait();
      int stalls = 0;
      int writes = 0;
      next_cycle();
      x_store_i = 1'b1; x_dm_addr_i = 32'h100;
      settle();
      stalls += int'(w_stall_req_o); writes += int'(rf_rd_write_o);
      next_cycle();
      settle();
      stalls += int'(w_stall_req_o); writes += int'(rf_rd_write_o);
      next_cycle();
      dm_store_done_i = 1'b1;
      settle();
      $display("txn store stall_cycles=%0d", stalls);
      n_checks++; if ({w_stall_req_o, rf_rd_write_o} !== 2'b00) begin n_fail++; $display("FAIL store_done got stall=%b w=%b exp 0 0", w_stall_req_o, rf_rd_write_o); end
      n_checks++; if (stalls !== 2 || writes !== 0) begin n_fail++; $display("FAIL store_wait got stalls=%0d writes=%0d exp 2 0", stalls, writes); end
      next_cycle();
      x_rd_write_i = 1'b1; x_rd_i = 5'd11; x_rd_value_i = 32'h55;
      settle();
      n_checks++; if ({rf_rd_write_o, rf_rd_o, rf_rd_value_o, w_stall_req_o} !== {1'b1, 5'd11, 32'h55, 1'b0}) begin n_fail++; $display("FAIL store_held_alu got w=%b rd=%0d val=%h stall=%b exp w=1 rd=11 val=00000055 stall=0", rf_rd_write_o, rf_rd_o, rf_rd_value_o, w_stall_req_o); end
      next_cycle();
      x_store_i = 1'b1; dm_store_done_i = 1'b1;
      settle();
      $display("txn store zero-wait");
      n_checks++; if ({w_stall_req_o, rf_rd_write_o} !== 2'b00) begin n_fail++; $display("FAIL store0 got stall=%b w=%b exp 0 0", w_stall_req_o, rf_rd_write_o); end
   endtask

   task automatic test_watchdog(input logic with_done);
      int stalls = 0;
      int pulses = 0;
      logic [31:0] exp_val;
      exp_val = with_done ? 32'h11223344 : 32'h0;
      next_cycle();
      x_load_i = 1'b1; x_fun_i = 3'b010; x_rd_i = 5'd12; x_dm_addr_i = 32'h8;
      settle();
      stalls += int'(w_stall_req_o); pulses += int'(timeout_o);
      for (int c = 1; c < 4; c++) begin
         next_cycle();
         settle();
         stalls += int'(w_stall_req_o); pulses += int'(timeout_o);
      end
      next_cycle();
      if (with_done) begin
         dm_load_done_i = 1'b1; dm_data_l_i = 32'h11223344;
      end
      settle();
      $display("txn watchdog done=%b timeout=%b rd=%0d value=%h stall_cycles=%0d", with_done, timeout_o, rf_rd_o, rf_rd_value_o, stalls);
      n_checks++; if (stalls !== 4 || pulses !== 0) begin n_fail++; $display("FAIL wd_stall_%b got stalls=%0d early_pulses=%0d exp 4 0", with_done, stalls, pulses); end
      n_checks++; if ({timeout_o, w_stall_req_o} !== {~with_done, 1'b0}) begin n_fail++; $display("FAIL wd_pulse_%b got timeout=%b stall=%b exp timeout=%b stall=0", with_done, timeout_o, w_stall_req_o, ~with_done); end
      n_checks++; if ({rf_rd_write_o, rf_rd_o, rf_rd_value_o} !== {1'b1, 5'd12, exp_val}) begin n_fail++; $display("FAIL wd_rf_%b got w=%b rd=%0d val=%h exp w=1 rd=12 val=%h", with_done, rf_rd_write_o, rf_rd_o, rf_rd_value_o, exp_val); end
      next_cycle();
      settle();
      n_checks++; if ({timeout_o, w_stall_req_o} !== 2'b00) begin n_fail++; $display("FAIL wd_after_%b got timeout=%b stall=%b exp 0 0", with_done, timeout_o, w_stall_req_o); end
   endtask

   task automatic test_reset_mid_load();
      next_cycle();
      x_load_i = 1'b1; x_fun_i = 3'b010; x_rd_i = 5'd14;
      settle();
      next_cycle();
      settle();
      n_checks++; if ({w_stall_req_o, bypass_valid_o} !== 2'b11) begin n_fail++; $display("FAIL rstmid_pre got stall=%b bv=%b exp 1 1", w_stall_req_o, bypass_valid_o); end
      // Assert reset between clock edges; it must take effect at once.
      dm_load_done_i = 1'b1; dm_data_l_i = 32'hA5A5A5A5;
      rst_i = 1'b1;
      #1;
      $display("txn reset during load wait");
      n_checks++; if ({w_stall_req_o, rf_rd_write_o, bypass_valid_o} !== 3'b000) begin n_fail++; $display("FAIL rstmid_async got stall=%b w=%b bv=%b exp 0 0 0", w_stall_req_o, rf_rd_write_o, bypass_valid_o); end
      next_cycle();
      rst_i = 1'b0;
      next_cycle();
      dm_load_done_i = 1'b1; dm_data_l_i = 32'hA5A5A5A5;
      settle();
      n_checks++; if ({w_stall_req_o, rf_rd_write_o} !== 2'b00) begin n_fail++; $display("FAIL rstmid_late_done got stall=%b w=%b exp 0 0", w_stall_req_o, rf_rd_write_o); end
      next_cycle();
      settle();
      n_checks++; if (bypass_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_bypass got=%b exp=0", bypass_valid_o); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_zero_wait_load();
      test_delayed_load();
      test_store_wait();
      test_watchdog(1'b0);
      test_watchdog(1'b1);
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
